// File: rtl/tanh_approx_4bit_inverse_search.sv
// Sequential inverse of the 4-bit approximate tanh: scans all 16 input codes
// and returns the code whose forward output is nearest to the requested activation.
module tanh_approx_4bit_inverse_search #(
  parameter bit TIE_POLICY = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_x,
  output logic [3:0]   out_err,
  output logic         busy
);

  localparam int unsigned W = 4;
  localparam logic [W-1:0] LAST_X = W'(15);
  localparam logic [W-1:0] MAX_ERR = W'(15);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic [W-1:0]   cnt;
  logic [W-1:0]   y_r;
  logic [W-1:0]   best_x;
  logic [W-1:0]   best_err;
  logic [W-1:0]   f_cur;
  logic [W-1:0]   d_cur;
  logic           upd;

  // Copy of the approximate forward tanh used by the activation library
  function automatic logic [W-1:0] fwd(input logic [W-1:0] x);
    logic n;
    n = ~(x[1] & x[0]);
    return {~((x[3] | n) ^ x[1]), ~((x[2] | n) ^ x[1]), x[0], x[0]};
  endfunction

  always_comb begin
    f_cur = fwd(cnt);
    d_cur = (f_cur >= y_r) ? W'(f_cur - y_r) : W'(y_r - f_cur);
    upd   = TIE_POLICY ? (d_cur <= best_err) : (d_cur < best_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (cnt == LAST_X) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags registered from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Search datapath; result registers load on the final scan step and hold through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      y_r      <= '0;
      best_x   <= '0;
      best_err <= MAX_ERR;
      out_x    <= '0;
      out_err  <= '0;
    end else if (accept) begin
      y_r      <= in_y;
      cnt      <= '0;
      best_x   <= '0;
      best_err <= MAX_ERR;
    end else if (state == SCAN) begin
      cnt <= W'(cnt + W'(1));
      if (upd) begin
        best_x   <= cnt;
        best_err <= d_cur;
      end
      if (cnt == LAST_X) begin
        out_x   <= upd ? cnt   : best_x;
        out_err <= upd ? d_cur : best_err;
      end
    end
  end

endmodule

// File: tb/tb_tanh_approx_4bit_inverse_search.sv
// Scoreboard bench: two instances (lowest-x and highest-x tie policies) share stimulus.
module tb_tanh_approx_4bit_inverse_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_y = 4'd0;

  logic       in_ready0, out_valid0, busy0;
  logic [3:0] out_x0, out_err0;
  logic       in_ready1, out_valid1, busy1;
  logic [3:0] out_x1, out_err1;

  tanh_approx_4bit_inverse_search #(.TIE_POLICY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_y(in_y),
    .out_valid(out_valid0), .out_ready(out_ready), .out_x(out_x0), .out_err(out_err0),
    .busy(busy0)
  );

  tanh_approx_4bit_inverse_search #(.TIE_POLICY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_y(in_y),
    .out_valid(out_valid1), .out_ready(out_ready), .out_x(out_x1), .out_err(out_err1),
    .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         acc0[$];
  int         acc1[$];
  logic       ov0_d = 1'b0;
  logic       ov1_d = 1'b0;
  logic [7:0] e0, e1;

  function automatic logic [7:0] pk(input int x, input int e);
    return {4'(x), 4'(e)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor for the lowest-x instance
  always @(negedge clk) begin
    if (!rst_n) ov0_d = 1'b0;
    else begin
      if (in_valid && in_ready0) acc0.push_back(cyc + 1);
      if (out_valid0 && !ov0_d) begin
        if (acc0.size() == 0) fail("latency0_no_accept");
        else check("latency0", cyc - acc0.pop_front(), 16);
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) fail("unexpected_result0");
        else begin
          e0 = q0.pop_front();
          check("out_x0", int'(out_x0), int'(e0[7:4]));
          check("out_err0", int'(out_err0), int'(e0[3:0]));
        end
      end
      ov0_d = out_valid0;
    end
  end

  // Monitor for the highest-x instance
  always @(negedge clk) begin
    if (!rst_n) ov1_d = 1'b0;
    else begin
      if (in_valid && in_ready1) acc1.push_back(cyc + 1);
      if (out_valid1 && !ov1_d) begin
        if (acc1.size() == 0) fail("latency1_no_accept");
        else check("latency1", cyc - acc1.pop_front(), 16);
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) fail("unexpected_result1");
        else begin
          e1 = q1.pop_front();
          check("out_x1", int'(out_x1), int'(e1[7:4]));
          check("out_err1", int'(out_err1), int'(e1[3:0]));
        end
      end
      ov1_d = out_valid1;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) fail("in_ready_timeout");
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid0) fail("out_valid_timeout");
  endtask

  task automatic req(input logic [3:0] y, input logic [7:0] x0, input logic [7:0] x1);
    q0.push_back(x0);
    q1.push_back(x1);
    in_y = y;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] y, input logic [7:0] x0, input logic [7:0] x1);
    req(y, x0, x1);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, int'(in_ready0), 1);
    check({tag, "_out_valid"}, int'(out_valid0), 0);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_out_x"}, int'(out_x0), 0);
    check({tag, "_out_err"}, int'(out_err0), 0);
    check({tag, "_out_valid1"}, int'(out_valid1), 0);
  endtask

  logic [3:0] ys[3];
  logic [7:0] ex0[3];
  logic [7:0] ex1[3];
  int         acc_t[3];
  logic [3:0] sx0, se0, sx1;

  initial begin
    ys  = '{4'd3, 4'd11, 4'd0};
    ex0 = '{pk(1, 0), pk(11, 0), pk(0, 0)};
    ex1 = '{pk(13, 0), pk(11, 0), pk(12, 0)};

    repeat (2) @(posedge clk);
    #1 check_reset_values("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Abort a scan with reset; the pending result must vanish
    req(4'd5, pk(1, 2), pk(13, 2));
    repeat (5) @(posedge clk);
    #1 check("scan_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1 check_reset_values("midscan");
    q0.delete(); q1.delete(); acc0.delete(); acc1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(4'd15, pk(15, 0), pk(15, 0));

    // Exact hits
    run(4'd0,  pk(0, 0), pk(12, 0));
    run(4'd7,  pk(7, 0), pk(7, 0));
    run(4'd12, pk(2, 0), pk(14, 0));

    // Nearest match with ties
    run(4'd5,  pk(1, 2), pk(13, 2));
    run(4'd9,  pk(7, 2), pk(11, 2));
    run(4'd13, pk(2, 1), pk(14, 1));

    // Back-pressure with an ignored request in the window
    out_ready = 1'b0;
    req(4'd13, pk(2, 1), pk(14, 1));
    wait_valid();
    sx0 = out_x0; se0 = out_err0; sx1 = out_x1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        in_y = 4'd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_out_x0", int'(out_x0), int'(sx0));
      check("bp_out_err0", int'(out_err0), int'(se0));
      check("bp_out_x1", int'(out_x1), int'(sx1));
      check("bp_in_ready", int'(in_ready0), 0);
      check("bp_out_valid", int'(out_valid0), 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_in_ready_after", int'(in_ready0), 1);

    // Back-to-back requests with in_valid held and in_y disturbed mid-scan
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q0.push_back(ex0[k]);
      q1.push_back(ex1[k]);
      in_y = ys[k];
      wait_ready();
      @(posedge clk);
      #1 acc_t[k] = cyc;
      if (k == 2) in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 in_y = ~ys[k];
      wait_valid();
      @(posedge clk);
      #1;
    end
    check("spacing_1", acc_t[1] - acc_t[0], 18);
    check("spacing_2", acc_t[2] - acc_t[1], 18);

    repeat (30) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tanh_approx_4bit_inverse_search.md
# tanh_approx_4bit_inverse_search

Sequential inverse for the team's 4-bit approximate tanh circuit. It accepts a 4-bit activation code y over a valid/ready handshake and scans all 16 input codes through an internal copy of the approximate forward function. It returns the input code x whose forward output is nearest to y, together with the absolute error. It sits downstream of the activation library, where it is used for characterisation and for back-mapping activations to pre-activation codes.

## Interface
- TIE_POLICY, 0: tie-break among equal-error candidates; 0 = lowest x wins, 1 = highest x wins.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_y  in  4  target activation code, unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_x  out  4  best-matching input code.
- out_err  out  4  |f(out_x) − y|, unsigned.
- busy  out  1  high in SCAN or DONE.

## Operation
- Forward function f(x), with x = x3..x0:
  - n = ~(x1 & x0)
  - f0 = f1 = x0
  - f2 = ~((x2 | n) ^ x1)
  - f3 = ~((x3 | n) ^ x1)
- Resulting map for x = 0..15: 0, 3, 12, 3, 0, 3, 12, 7, 0, 3, 12, 11, 0, 3, 12, 15.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready = 1. When in_valid & in_ready, capture in_y into y_r. In the same edge, clear cnt to 0, preset best_err to 15 and best_x to 0, then go to SCAN.
- SCAN: each cycle evaluate f(cnt) and d = |f(cnt) − y_r|, computed in 5-bit signed or by compare-and-subtract, result 4 bits.
  - TIE_POLICY = 0: update best when d < best_err.
  - TIE_POLICY = 1: update best when d <= best_err.
  - cnt increments each cycle. After evaluating cnt = 15, go to DONE. cnt does not wrap into a second scan.
- DONE: out_valid = 1. out_x and out_err are driven from best_x and best_err and stay stable while out_valid is high. On out_valid & out_ready, go to IDLE.
- in_y, and in_valid outside IDLE, are ignored. No request is queued.
- out_ready outside DONE has no effect.

## Timing
- Reset values, asynchronous and immediate:
  - state IDLE, in_ready 1, out_valid 0, busy 0.
  - out_x 0, out_err 0, cnt 0, y_r 0.
- Latency: with the accept edge as E0, edges E1..E16 evaluate x = 0..15, and out_valid rises after E16. That is 16 cycles from accept to out_valid.
- in_ready drops after E0 and returns one cycle after the output handshake edge.
- Minimum request-to-request interval is 18 cycles, with out_ready tied high.
- Back-pressure: DONE holds indefinitely while out_ready = 0. Outputs do not change.
- Reset asserted mid-SCAN or in DONE aborts the operation, drops out_valid, and discards the pending result. The first request after reset release is handled normally.
- All outputs are registered. There is no combinational path from in_* to out_*, and in_ready depends only on state.

## Test plan
- Reset: assert rst_n = 0 mid-SCAN. Required: outputs go to their reset values immediately. Then release reset, request y = 15. Required: out_x = 15, out_err = 0.
- Exact hits, TIE_POLICY = 0: y = 0 → x = 0, err = 0; y = 7 → x = 7, err = 0; y = 12 → x = 2, err = 0. Each out_valid must rise exactly 16 cycles after the accept edge.
- Nearest and tie behaviour, TIE_POLICY = 0: y = 5 → x = 1, err = 2; y = 9 → x = 7, err = 2; y = 13 → x = 2, err = 1.
- Same stimulus with TIE_POLICY = 1: y = 5 → x = 13, err = 2; y = 9 → x = 11, err = 2; y = 13 → x = 14, err = 1.
- Back-pressure: hold out_ready = 0 for 10 cycles after out_valid rises.
  - Required: out_x and out_err stable, in_ready = 0.
  - A new in_valid pulse during this window is ignored.
  - After out_ready is asserted, in_ready rises the next cycle.
- Throughput and isolation: back-to-back requests with in_valid and out_ready held high, sequence y = 3, 11, 0. Required results: x = 1, 11, 0. Required spacing: 18 cycles. Changing in_y mid-SCAN must not alter the result.
